// File: rtl/align_mantissa.sv
// Mantissa alignment stage: shifts the smaller operand right, SHIFT_STEP bits per cycle.
// Ports: in_valid/in_ready operand handshake; out_valid/out_ready result handshake;
// expA/expB, manA/manB, sign, numbershift in; exp_big, man_big, man_small {m,G,R,S}, swapped out.
module align_mantissa #(
   parameter int SHIFT_STEP = 4,
   parameter int MAN_W      = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       expA,
   input  logic [7:0]       expB,
   input  logic [MAN_W-1:0] manA,
   input  logic [MAN_W-1:0] manB,
   input  logic             sign,
   input  logic [4:0]       numbershift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       exp_big,
   output logic [MAN_W-1:0] man_big,
   output logic [MAN_W+2:0] man_small,
   output logic             swapped
);

   localparam int         W    = MAN_W + 3;
   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_d;
   logic [W-1:0]     work;
   logic [4:0]       rem;
   logic             accept;
   logic             far;
   logic [MAN_W-1:0] src;
   logic [4:0]       s;
   logic [W-1:0]     mask;
   logic [W-1:0]     shifted;
   logic             lost;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign man_small = work;

   assign accept = in_valid && in_ready;
   // zero shift with unequal exponents means the gap is >= MAN_W
   assign far    = (numbershift == 5'd0) && (expA != expB);
   assign src    = sign ? manA : manB;

   assign s       = (rem < STEP) ? rem : STEP;
   assign mask    = ({{(W-1){1'b0}}, 1'b1} << s) - {{(W-1){1'b0}}, 1'b1};
   assign shifted = work >> s;
   // covers every bit leaving the word, old sticky included
   assign lost    = |(work & mask);

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (far || numbershift == 5'd0)
                  state_d = DONE;
               else
                  state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (rem == s)
               state_d = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_big <= '0;
         man_big <= '0;
         swapped <= 1'b0;
         work    <= '0;
         rem     <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            exp_big <= sign ? expB : expA;
            man_big <= sign ? manB : manA;
            swapped <= sign;
            rem     <= numbershift;
            if (far)
               work <= {{(W-1){1'b0}}, |src};
            else
               work <= {src, 3'b000};
         end
      end else if (state == SHIFT) begin
         work <= {shifted[W-1:1], shifted[0] | lost};
         rem  <= rem - s;
      end
   end

endmodule

// File: tb/tb_align_mantissa.sv
// Directed bench for align_mantissa: latency, aligned values, backpressure, async reset.
// Compares every observable against hand-computed constants.
module tb_align_mantissa;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  expA = '0;
   logic [7:0]  expB = '0;
   logic [23:0] manA = '0;
   logic [23:0] manB = '0;
   logic        sign = 1'b0;
   logic [4:0]  numbershift = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  exp_big;
   logic [23:0] man_big;
   logic [26:0] man_small;
   logic        swapped;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   align_mantissa #(.SHIFT_STEP(4), .MAN_W(24)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .expA(expA),
      .expB(expB),
      .manA(manA),
      .manB(manB),
      .sign(sign),
      .numbershift(numbershift),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .exp_big(exp_big),
      .man_big(man_big),
      .man_small(man_small),
      .swapped(swapped)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input logic sg, input logic [4:0] ns);
      expA = ea;
      expB = eb;
      manA = ma;
      manB = mb;
      sign = sg;
      numbershift = ns;
      in_valid = 1'b1;
      check("in_ready_pre", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // scramble inputs; operation in flight must ignore them
      expA = 8'hEE;
      expB = 8'h11;
      manA = 24'h5A5A5A;
      manB = 24'hA5A5A5;
      sign = ~sg;
      numbershift = 5'd17;
   endtask

   task automatic run_op(input string tag,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [23:0] ma, input logic [23:0] mb,
                         input logic sg, input logic [4:0] ns,
                         input int x_lat, input logic [7:0] x_exp,
                         input logic [23:0] x_big, input logic [26:0] x_small,
                         input logic x_sw, input int hold);
      int n;
      drive(ea, eb, ma, mb, sg, ns);
      n = 1;
      while (!out_valid && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(x_lat));
      check({tag, "_exp"}, 32'(exp_big), 32'(x_exp));
      check({tag, "_big"}, 32'(man_big), 32'(x_big));
      check({tag, "_small"}, 32'(man_small), 32'(x_small));
      check({tag, "_sw"}, 32'(swapped), 32'(x_sw));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
         check({tag, "_hold_small"}, 32'(man_small), 32'(x_small));
         check({tag, "_hold_big"}, 32'(man_big), 32'(x_big));
         check({tag, "_hold_exp"}, 32'(exp_big), 32'(x_exp));
      end
      out_ready = 1'b1;
      check({tag, "_rdy_at_hs"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_v_after"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_exp", 32'(exp_big), 32'd0);
      check("rst_small", 32'(man_small), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("basic", 8'h85, 8'h80, 24'hC00000, 24'h800001, 1'b0, 5'd5,
             3, 8'h85, 24'hC00000, 27'h0200001, 1'b0, 0);
      run_op("equal", 8'h7F, 8'h7F, 24'h123456, 24'hABCDEF, 1'b0, 5'd0,
             1, 8'h7F, 24'h123456, 27'h55E6F78, 1'b0, 0);
      run_op("far", 8'h10, 8'h40, 24'h800000, 24'h900000, 1'b1, 5'd0,
             1, 8'h40, 24'h900000, 27'h0000001, 1'b1, 0);
      run_op("max", 8'h97, 8'h80, 24'h800000, 24'hFFFFFF, 1'b0, 5'd23,
             7, 8'h97, 24'h800000, 27'h000000F, 1'b0, 0);
      run_op("step8", 8'h88, 8'h80, 24'hA00000, 24'h000100, 1'b0, 5'd8,
             3, 8'h88, 24'hA00000, 27'h0000008, 1'b0, 0);
      run_op("bp", 8'h85, 8'h80, 24'hC00000, 24'h800001, 1'b0, 5'd5,
             3, 8'h85, 24'hC00000, 27'h0200001, 1'b0, 5);

      drive(8'h97, 8'h80, 24'h800000, 24'hFFFFFF, 1'b0, 5'd23);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_small", 32'(man_small), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("post_rst", 8'h80, 8'h81, 24'h800001, 24'hF00000, 1'b1, 5'd1,
             2, 8'h81, 24'hF00000, 27'h2000004, 1'b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
